// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every signal between the CPU memory-port arbiter, the two pipeline
// requesters (IF fetch, MEM data) and the single memory/NoC port.
//   Fetch side : if_req, if_addr -> ; <- if_rdata, if_valid, if_stall
//   Data side  : d_req, d_we, d_addr, d_wdata -> ; <- d_rdata, d_valid, d_stall
//   Memory side: <- mem_req, mem_we, mem_addr, mem_wdata ; mem_gnt, mem_rvalid, mem_rdata ->
// Modports:
//   slave  - the arbiter's view: it serves the pipeline and drives the memory request.
//   master - the environment's view: pipeline requesters plus the memory responder.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction fetch requester
    logic              if_req;
    logic [0:ADDR_W-1] if_addr;
    logic [0:DATA_W-1] if_rdata;
    logic              if_valid;
    logic              if_stall;

    // Data requester
    logic              d_req;
    logic              d_we;
    logic [0:ADDR_W-1] d_addr;
    logic [0:DATA_W-1] d_wdata;
    logic [0:DATA_W-1] d_rdata;
    logic              d_valid;
    logic              d_stall;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [0:ADDR_W-1] mem_addr;
    logic [0:DATA_W-1] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [0:DATA_W-1] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_valid, if_stall,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_valid, if_stall,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the CPU's single memory port between the IF fetch requester and the MEM data
// requester. One transaction is in flight at a time: IDLE arbitrates and latches the
// winning request, ISSUE presents it on the memory port until mem_gnt, WAIT waits for
// mem_rvalid and hands the response back to the owner. Per-requester stalls hold the
// IF pc / MEM stage until their own response is delivered.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low; clears all state immediately
//   bus   - mem_port_arbiter_if.slave (requester handshakes and memory port)
module mem_port_arbiter (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic {
        OwnerIf   = 1'b0,
        OwnerData = 1'b1
    } owner_e;

    state_e state;
    owner_e owner;
    owner_e last_owner;

    logic any_req;
    logic pick_data;
    logic resp_now;
    logic if_match;
    logic d_match;

    assign any_req = bus.if_req | bus.d_req;

    // Round-robin on a tie: data wins only if IF was the last one granted.
    assign pick_data = bus.d_req & (~bus.if_req | (last_owner == OwnerIf));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            owner         <= OwnerIf;
            last_owner    <= OwnerData;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state       <= StIssue;
                        bus.mem_req <= 1'b1;
                        if (pick_data) begin
                            owner         <= OwnerData;
                            last_owner    <= OwnerData;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            // Fetches never write; keep the write fields quiet.
                            owner         <= OwnerIf;
                            last_owner    <= OwnerIf;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_we    <= 1'b0;
                            bus.mem_wdata <= '0;
                        end
                    end
                end
                StIssue: begin
                    // Latched fields stay untouched until the memory accepts them.
                    if (bus.mem_gnt) begin
                        state       <= StWait;
                        bus.mem_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state       <= StIdle;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // A response is only handed back if the owner still wants that same address;
    // otherwise (e.g. a fetch redirected by a branch) it is dropped silently.
    assign resp_now = (state == StWait) & bus.mem_rvalid;
    assign if_match = bus.if_req & (bus.if_addr == bus.mem_addr);
    assign d_match  = bus.d_req & (bus.d_addr == bus.mem_addr);

    always_comb begin
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;
        if (resp_now) begin
            if (owner == OwnerIf) begin
                bus.if_valid = if_match;
            end else begin
                bus.d_valid = d_match;
            end
        end
    end

    assign bus.if_rdata = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

    assign bus.if_stall = bus.if_req & ~bus.if_valid;
    assign bus.d_stall  = bus.d_req & ~bus.d_valid;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Grants one requester at a time, holds exactly one transaction in flight, and generates the per-requester stall signals that freeze the IF program counter and the MEM stage until their data returns. Sits between the pipeline stages and the memory/NoC interface.

## Interface
- ADDR_W, 32, address width, all address buses [0:ADDR_W-1]
- DATA_W, 32, data width, all data buses [0:DATA_W-1]

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address (IF pc_out)
- if_rdata  out  DATA_W  fetched instruction; meaningful only while if_valid=1
- if_valid  out  1  one-cycle pulse: fetch completed
- if_stall  out  1  freeze IF pc
- d_req  in  1  data request; held high until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; meaningful only while d_valid=1 and the transaction is a load
- d_valid  out  1  one-cycle pulse: load data returned or store acknowledged
- d_stall  out  1  freeze MEM stage
- mem_req  out  1  request to memory
- mem_we  out  1  write enable, stable while mem_req=1
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response/ack; arrives at least 1 cycle after mem_gnt
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request is present, arbitrate, latch owner, addr, we, and wdata (we and wdata forced to 0 for IF), then go to ISSUE. Otherwise stay in IDLE.
- Arbitration is round-robin on a last_owner bit. When both requests are high, grant the one that was not last granted. A single requester always wins. Reset sets last_owner=DATA, so IF wins the first tie. last_owner updates at grant.
- ISSUE: mem_req=1, driven with the latched fields. On mem_gnt=1, go to WAIT. Otherwise stay in ISSUE, with the fields unchanged.
- WAIT: mem_req=0. On mem_rvalid=1, go to IDLE. mem_rvalid is ignored in IDLE and ISSUE.
- Response delivery happens in the WAIT cycle with mem_rvalid=1, combinationally:
  - The owner's valid is asserted only if the owner's req is still 1 and its current addr equals the latched addr.
  - Otherwise the response is discarded silently (e.g., IF redirected by a branch while stalled), and the FSM still returns to IDLE.
- if_rdata and d_rdata are combinational passthroughs of mem_rdata.
- Stall: if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid. Both are combinational, including during reset.
- A new request is never accepted while ISSUE or WAIT is active. The other requester simply stalls.

## Timing
- Reset values: state=IDLE, last_owner=DATA, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0.
- Reset asserted mid-transaction: mem_req drops asynchronously. A later mem_rvalid for the aborted transaction is ignored, because the FSM is in IDLE.
- Best-case latency with mem_gnt in the first ISSUE cycle and mem_rvalid one cycle later:
  - req seen in IDLE at cycle 0, mem_req at cycle 1, valid at cycle 2.
  - The requester stalls in cycles 0–1 and is released in cycle 2.
- Peak throughput: one transaction per 3 cycles, since the FSM returns to IDLE in the cycle after valid.
- Each extra cycle without mem_gnt, or with mem_rvalid late, adds one cycle of latency.
- A stall on the losing requester lasts until its own transaction completes.

## Test plan
- Single fetch: if_req=1, if_addr=0x00000010, mem_gnt=1 at cycle 1, mem_rvalid=1 with mem_rdata=0xDEADBEEF at cycle 2 -> mem_req only at cycle 1 with mem_addr=0x10; if_valid=1 and if_rdata=0xDEADBEEF at cycle 2; if_stall=1 at cycles 0–1 and 0 at cycle 2.
- Tie, round-robin: if_req and d_req held high continuously, memory always grants immediately -> grants alternate IF, DATA, IF, DATA; valids arrive at cycles 2, 5, 8, 11; the other requester's stall stays high meanwhile.
- Store with backpressure: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678, mem_gnt low for 3 cycles -> mem_req, mem_we, mem_addr, and mem_wdata hold stable for 4 ISSUE cycles; d_valid pulses once, in the mem_rvalid cycle.
- Branch redirect: IF granted at 0x20, if_addr changes to 0x80 before mem_rvalid -> no if_valid pulse; FSM returns to IDLE; next cycle a new fetch is issued at 0x80.
- Async reset in WAIT: reset=0 mid-cycle -> mem_req=0 and state=IDLE immediately; a mem_rvalid after reset release produces no valid pulse.
